// File: rtl/sega6_pkg.sv
// rtl/sega6_pkg.sv - shared constants for the Sega DB9 pad reader
// Purpose: scan phase numbers, raw pin indices and output word field indices.
// Output word layout (active-low): [11]=M [10]=X [9]=Y [8]=Z [7]=S [6]=A [5]=C [4]=B [3]=R [2]=L [1]=D [0]=U
package sega6_pkg;

   // Scan phases with an action; every later phase just parks select high.
   localparam int PH_SEL_LO0 = 0;
   localparam int PH_SEL_HI0 = 1;
   localparam int PH_DPAD    = 2;
   localparam int PH_START_A = 3;
   localparam int PH_SEL_LO2 = 4;
   localparam int PH_SIX_DET = 5;
   localparam int PH_XYZM    = 6;

   // Raw pin vector layout {p9,p6,right,left,down,up}
   localparam int PIN_U  = 0;
   localparam int PIN_D  = 1;
   localparam int PIN_L  = 2;
   localparam int PIN_R  = 3;
   localparam int PIN_P6 = 4;
   localparam int PIN_P9 = 5;

   // Output word fields
   localparam int B_U = 0;
   localparam int B_D = 1;
   localparam int B_L = 2;
   localparam int B_R = 3;
   localparam int B_B = 4;
   localparam int B_C = 5;
   localparam int B_A = 6;
   localparam int B_S = 7;
   localparam int B_Z = 8;
   localparam int B_Y = 9;
   localparam int B_X = 10;
   localparam int B_M = 11;

   localparam logic [11:0] IDLE_WORD = 12'hFFF;

endpackage

// File: rtl/sega6_port_decode.sv
// rtl/sega6_port_decode.sv - per-port button word and six-button flag decoder
// Ports:
//   clk, reset  : clock_48 domain clock, async active-high reset
//   tick        : scan strobe; the action of the current phase runs on it
//   phase       : current scan phase (before increment)
//   pins        : synchronised pad pins {p9,p6,right,left,down,up}
//   word        : registered active-low MXYZ SACB RLDU word
//   six         : six-button pad seen during the last completed scan
module sega6_port_decode
   import sega6_pkg::*;
#(
   parameter int PHASE_BITS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic [PHASE_BITS-1:0] phase,
   input  logic [5:0]            pins,
   output logic [11:0]           word,
   output logic                  six
);

   // Set when the third select-low pulse reads all directions low, which
   // only a six-button pad does; published at the XYZM phase.
   logic six_tmp;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word    <= IDLE_WORD;
         six_tmp <= 1'b0;
         six     <= 1'b0;
      end else if (tick) begin
         case (phase)
            PHASE_BITS'(PH_DPAD): begin
               word[B_R:B_U] <= pins[PIN_R:PIN_U];
               word[B_C:B_B] <= pins[PIN_P9:PIN_P6];
               six_tmp       <= 1'b0;
            end
            PHASE_BITS'(PH_START_A): begin
               // R and L both low with select low identifies a Mega Drive pad;
               // otherwise it is a Master System pad with no Start/A.
               if (!pins[PIN_R] && !pins[PIN_L])
                  word[B_S:B_A] <= pins[PIN_P9:PIN_P6];
               else
                  word[B_S:B_B] <= {2'b11, pins[PIN_P9:PIN_P6]};
            end
            PHASE_BITS'(PH_SIX_DET): begin
               if (pins[PIN_R:PIN_U] == 4'b0000)
                  six_tmp <= 1'b1;
            end
            PHASE_BITS'(PH_XYZM): begin
               word[B_M:B_Z] <= six_tmp ? pins[PIN_R:PIN_U] : 4'hF;
               six           <= six_tmp;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sega6_joy_reader.sv
// rtl/sega6_joy_reader.sv - two-port Sega DB9 joystick scanner (SMS 2-btn, MD 3/6-btn)
// Ports:
//   clk          : clock_48 domain clock
//   reset        : async active-high reset
//   scan_tick    : single-cycle strobe advancing the scan phase
//   joy1_pins_i  : raw port 1 pins, active-low {p9,p6,right,left,down,up}
//   joy2_pins_i  : raw port 2 pins, same layout
//   joyX_p7_o    : shared pad select line
//   joy1_s/joy2_s: active-low MXYZ SACB RLDU words
//   joy1_six/joy2_six : six-button pad detected on the last completed scan
module sega6_joy_reader
   import sega6_pkg::*;
#(
   parameter int PHASE_BITS  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scan_tick,
   input  logic [5:0]  joy1_pins_i,
   input  logic [5:0]  joy2_pins_i,
   output logic        joyX_p7_o,
   output logic [11:0] joy1_s,
   output logic [11:0] joy2_s,
   output logic        joy1_six,
   output logic        joy2_six
);

   logic [5:0]            j1_sync [SYNC_STAGES];
   logic [5:0]            j2_sync [SYNC_STAGES];
   logic [PHASE_BITS-1:0] phase;

   // Synchronisers preset to all-ones so a reset looks like an idle pad.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            j1_sync[i] <= '1;
            j2_sync[i] <= '1;
         end
      end else begin
         j1_sync[0] <= joy1_pins_i;
         j2_sync[0] <= joy2_pins_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            j1_sync[i] <= j1_sync[i-1];
            j2_sync[i] <= j2_sync[i-1];
         end
      end
   end

   // Free-running phase counter; natural binary wrap closes the scan cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         phase <= '0;
      else if (scan_tick)
         phase <= phase + 1'b1;
   end

   // Select goes low on the even phases up to XYZM and stays high for the
   // rest of the cycle so the pad's internal counter times out and resets.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         joyX_p7_o <= 1'b1;
      else if (scan_tick)
         joyX_p7_o <= !((phase <= PHASE_BITS'(PH_XYZM)) && !phase[0]);
   end

   sega6_port_decode #(.PHASE_BITS(PHASE_BITS)) u_port1 (
      .clk   (clk),
      .reset (reset),
      .tick  (scan_tick),
      .phase (phase),
      .pins  (j1_sync[SYNC_STAGES-1]),
      .word  (joy1_s),
      .six   (joy1_six)
   );

   sega6_port_decode #(.PHASE_BITS(PHASE_BITS)) u_port2 (
      .clk   (clk),
      .reset (reset),
      .tick  (scan_tick),
      .phase (phase),
      .pins  (j2_sync[SYNC_STAGES-1]),
      .word  (joy2_s),
      .six   (joy2_six)
   );

endmodule
